cpu_sequencer: RTL and testbench

//   Instruction-cycle controller for the 8-bit accumulator CPU. Steps each

---
 rtl/cpu_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Instruction-cycle controller for the 8-bit accumulator CPU: eight-phase sequencer with memory wait states and timeout.
// Optional single-step mode is enabled by defining CPU_SEQ_STEP_EN.
module cpu_sequencer #(
  parameter int OPC_W    = 3,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             mem_ack,
  input  logic             resume,
`ifdef CPU_SEQ_STEP_EN
  input  logic             step,
`endif
  output logic             sel,
  output logic             rd,
  output logic             wr,
  output logic             mem_req,
  output logic             ld_ir,
  output logic             ld_ac,
  output logic             ld_pc,
  output logic             inc_pc,
  output logic             data_e,
  output logic             halt,
  output logic             bus_err,
  output logic [2:0]       phase,
  output logic             instr_done
);

  localparam int WCW = $clog2(MAX_WAIT + 1);

  localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_SKZ = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_AND = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_XOR = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_STO = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(7);

  typedef enum logic [3:0] {
    ST_ADDR,
    ST_FETCH,
    ST_LOAD,
    ST_IDLE,
    ST_OPADDR,
    ST_OPFETCH,
    ST_ALU,
    ST_STORE,
`ifdef CPU_SEQ_STEP_EN
    ST_WAITSTEP,
`endif
    ST_HALTED
  } state_t;

  state_t         state_q, state_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic           bus_err_q, bus_err_d;
  logic           aluop, is_sto, is_jmp, is_skz, is_hlt;
  logic           stall;

  assign aluop  = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);
  assign is_sto = (opcode == OP_STO);
  assign is_jmp = (opcode == OP_JMP);
  assign is_skz = (opcode == OP_SKZ);
  assign is_hlt = (opcode == OP_HLT);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ADDR;
      wait_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end

  // NOTE: every output and next-state value is defaulted first so no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    bus_err_d = bus_err_q;
    sel       = 1'b0;
    rd        = 1'b0;
    wr        = 1'b0;
    mem_req   = 1'b0;
    ld_ir     = 1'b0;
    ld_ac     = 1'b0;
    ld_pc     = 1'b0;
    inc_pc    = 1'b0;
    data_e    = 1'b0;
    halt      = 1'b0;
    phase     = 3'd0;

    case (state_q)
      ST_ADDR: begin
        sel     = 1'b1;
        phase   = 3'd0;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        sel     = 1'b1;
        rd      = 1'b1;
        mem_req = 1'b1;
        phase   = 3'd1;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        sel     = 1'b1;
        rd      = 1'b1;
        ld_ir   = 1'b1;
        phase   = 3'd2;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        sel     = 1'b1;
        rd      = 1'b1;
        ld_ir   = 1'b1;
        phase   = 3'd3;
        state_d = ST_OPADDR;
      end
      ST_OPADDR: begin
        inc_pc  = 1'b1;
        halt    = is_hlt;
        phase   = 3'd4;
        state_d = is_hlt ? ST_HALTED : ST_OPFETCH;
      end
      ST_OPFETCH: begin
        rd      = aluop;
        mem_req = aluop;
        phase   = 3'd5;
        state_d = ST_ALU;
      end
      ST_ALU: begin
        rd      = aluop;
        ld_ac   = aluop;
        inc_pc  = is_skz && zero;
        ld_pc   = is_jmp;
        data_e  = is_sto;
        phase   = 3'd6;
        state_d = ST_STORE;
      end
      ST_STORE: begin
        rd      = aluop;
        ld_ac   = aluop;
        inc_pc  = is_jmp;
        ld_pc   = is_jmp;
        data_e  = is_sto;
        wr      = is_sto;
        mem_req = is_sto;
        phase   = 3'd7;
`ifdef CPU_SEQ_STEP_EN
        state_d = ST_WAITSTEP;
`else
        state_d = ST_ADDR;
`endif
      end
`ifdef CPU_SEQ_STEP_EN
      ST_WAITSTEP: begin
        phase = 3'd0;
        if (step) state_d = ST_ADDR;
      end
`endif
      ST_HALTED: begin
        halt  = 1'b1;
        phase = 3'd4;
        if (resume && !bus_err_q) state_d = ST_ADDR;
      end
      default: state_d = ST_ADDR;
    endcase

    // mem_req is only raised in wait-capable phases, so this covers FETCH, OPFETCH and STORE.
    if (mem_req && !mem_ack) begin
      if (wait_q == WCW'(MAX_WAIT)) begin
        bus_err_d = 1'b1;
        state_d   = ST_HALTED;
      end else begin
        state_d = state_q;
        wait_d  = wait_q + 1'b1;
      end
    end
  end

  assign stall      = mem_req && !mem_ack;
  assign instr_done = (state_q == ST_STORE) && !stall;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: randomized instruction stream against a phase-table model, plus directed corner cases.
`timescale 1ns/1ps
module tb_cpu_sequencer;

  localparam int MW = 4;
  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, STO = 3'd6, JMP = 3'd7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic zero = 1'b0, mem_ack = 1'b0, resume = 1'b0, step = 1'b0;
  logic sel, rd, wr, mem_req, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, bus_err, instr_done;
  logic [2:0] phase;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cpu_sequencer #(.OPC_W(3), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ack(mem_ack), .resume(resume),
`ifdef CPU_SEQ_STEP_EN
    .step(step),
`endif
    .sel(sel), .rd(rd), .wr(wr), .mem_req(mem_req), .ld_ir(ld_ir), .ld_ac(ld_ac), .ld_pc(ld_pc),
    .inc_pc(inc_pc), .data_e(data_e), .halt(halt), .bus_err(bus_err), .phase(phase),
    .instr_done(instr_done)
  );

  // Order: phase, sel rd wr mem_req ld_ir ld_ac ld_pc inc_pc data_e, halt bus_err instr_done.
  function automatic logic [14:0] obs();
    return {phase, sel, rd, wr, mem_req, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, bus_err, instr_done};
  endfunction

  // kind 0 = normal phase p, 1 = halted, 2 = waiting for step.
  function automatic logic [14:0] model(input int kind, input int p, input logic [2:0] op,
                                        input logic z, input logic be, input logic done);
    logic alu, sto, jmp, skz, hlt;
    logic [8:0] s;
    if (kind == 1) return {3'd4, 9'b0, 1'b1, be, 1'b0};
    if (kind == 2) return {3'd0, 9'b0, 1'b0, be, 1'b0};
    alu = (op >= 3'd2) && (op <= 3'd5);
    sto = (op == STO);
    jmp = (op == JMP);
    skz = (op == SKZ);
    hlt = (op == HLT);
    s[8] = (p <= 3);                                             // sel
    s[7] = (p >= 1 && p <= 3) || (alu && p >= 5);                // rd
    s[6] = sto && p == 7;                                        // wr
    s[5] = (p == 1) || (alu && p == 5) || (sto && p == 7);       // mem_req
    s[4] = (p == 2 || p == 3);                                   // ld_ir
    s[3] = alu && (p == 6 || p == 7);                            // ld_ac
    s[2] = jmp && (p == 6 || p == 7);                            // ld_pc
    s[1] = (p == 4) || (skz && z && p == 6) || (jmp && p == 7);  // inc_pc
    s[0] = sto && (p == 6 || p == 7);                            // data_e
    return {3'(p), s, hlt && p == 4, be, done};
  endfunction

  // Runs one instruction from ADDR; dly<0 picks random ack delays, zm<0 random zero.
  task automatic run_instr(input logic [2:0] op, input int dly, input int zm, input int halt_len);
    logic [14:0] exp;
    for (int p = 0; p < 8; p++) begin
      bit memp = (p == 1) || (p == 5 && op >= 3'd2 && op <= 3'd5) || (p == 7 && op == STO);
      int d = memp ? ((dly < 0) ? int'($urandom_range(0, MW)) : dly) : 0;
      for (int w = 0; w <= d; w++) begin
        opcode  = op;
        zero    = (zm < 0) ? 1'($urandom) : 1'(zm);
        resume  = 1'($urandom);
        mem_ack = memp ? (w == d) : 1'($urandom);
        #1;
        exp = model(0, p, op, zero, 1'b0, p == 7 && w == d);
        n_cmp++;
        if (obs() !== exp) begin
          n_fail++;
          $display("FAIL instr op=%0d phase%0d wait%0d: got %b expected %b", op, p, w, obs(), exp);
        end
        @(negedge clk);
      end
      if (op == HLT && p == 4) begin
        resume = 1'b0;
        for (int h = 0; h <= halt_len; h++) begin
          resume = (h == halt_len);
          #1;
          n_cmp++;
          if (obs() !== model(1, 0, op, zero, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL halted cycle%0d: got %b expected %b", h, obs(), model(1, 0, op, zero, 1'b0, 1'b0));
          end
          @(negedge clk);
        end
        resume = 1'b0;
        return;
      end
    end
`ifdef CPU_SEQ_STEP_EN
    step = 1'b1;
    #1;
    n_cmp++;
    if (obs() !== model(2, 0, op, zero, 1'b0, 1'b0)) begin
      n_fail++;
      $display("FAIL waitstep: got %b expected %b", obs(), model(2, 0, op, zero, 1'b0, 1'b0));
    end
    @(negedge clk);
    step = 1'b0;
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if (obs() !== {3'd0, 1'b1, 11'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected %b", obs(), {3'd0, 1'b1, 11'b0});
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (phase !== 3'd1) begin
      n_fail++;
      $display("FAIL reset_advance: got phase %0d expected 1", phase);
    end
    do_reset();
  endtask

  task automatic test_add_no_wait();
    run_instr(ADD, 0, -1, 0);
  endtask

  task automatic test_skz();
    run_instr(SKZ, 0, 1, 0);
    run_instr(SKZ, 0, 0, 0);
  endtask

  task automatic test_sto_wait();
    run_instr(STO, 3, -1, 0);
    run_instr(JMP, 2, -1, 0);
  endtask

  task automatic test_hlt();
    run_instr(HLT, 0, -1, 10);
    opcode = ADD;
    #1;
    n_cmp++;
    if (obs() !== model(0, 0, ADD, zero, 1'b0, 1'b0)) begin
      n_fail++;
      $display("FAIL hlt_resume: got %b expected %b", obs(), model(0, 0, ADD, zero, 1'b0, 1'b0));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      logic [2:0] op = 3'($urandom);
      run_instr(op, -1, -1, int'($urandom_range(0, 5)));
    end
  endtask

  task automatic test_timeout();
    opcode  = ADD;
    mem_ack = 1'b0;
    resume  = 1'b0;
    @(negedge clk);  // ADDR -> FETCH
    for (int w = 0; w <= MW; w++) begin
      #1;
      n_cmp++;
      if (obs() !== model(0, 1, ADD, zero, 1'b0, 1'b0)) begin
        n_fail++;
        $display("FAIL timeout_fetch wait%0d: got %b expected %b", w, obs(), model(0, 1, ADD, zero, 1'b0, 1'b0));
      end
      @(negedge clk);
    end
    for (int h = 0; h < 6; h++) begin
      resume  = 1'b1;
      mem_ack = 1'($urandom);
      #1;
      n_cmp++;
      if (obs() !== model(1, 0, ADD, zero, 1'b1, 1'b0)) begin
        n_fail++;
        $display("FAIL timeout_halted cycle%0d: got %b expected %b", h, obs(), model(1, 0, ADD, zero, 1'b1, 1'b0));
      end
      @(negedge clk);
    end
    resume = 1'b0;
  endtask

  task automatic test_reset_mid_store();
    do_reset();
    #1;
    n_cmp++;
    if (bus_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_clears_bus_err: got %b expected 0", bus_err);
    end
    opcode = STO;
    for (int p = 0; p < 7; p++) begin
      mem_ack = 1'b1;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    @(negedge clk);  // held in STORE
    #1;
    n_cmp++;
    if ({phase, wr} !== {3'd7, 1'b1}) begin
      n_fail++;
      $display("FAIL store_wait_wr: got phase %0d wr %b expected phase 7 wr 1", phase, wr);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== {3'd0, 1'b1, 11'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_store: got %b expected %b", obs(), {3'd0, 1'b1, 11'b0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1;
    run_instr(ADD, -1, -1, 0);
  endtask

`ifdef CPU_SEQ_STEP_EN
  task automatic test_step();
    int dones = 0;
    opcode  = ADD;
    mem_ack = 1'b1;
    for (int c = 0; c < 60; c++) begin
      step = (c == 10 || c == 30);
      #1;
      if (c >= 10 && instr_done === 1'b1) dones++;
      @(negedge clk);
    end
    step = 1'b0;
    n_cmp++;
    if (dones != 2) begin
      n_fail++;
      $display("FAIL step_count: got %0d instr_done pulses expected 2", dones);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_add_no_wait();
    test_skz();
    test_sto_wait();
    test_hlt();
    test_random();
    test_timeout();
    test_reset_mid_store();
`ifdef CPU_SEQ_STEP_EN
    test_step();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
